matrix_slot_allocator: RTL and testbench
========================================

# matrix_slot_allocator

Base-address allocator and directory for the matrix store. Serves the address-request handshake from the UART input front end (dims request held high, one-cycle ready pulse back). Places each new matrix in a fixed 25-word slot and enforces a per-dimension capacity with oldest-first replacement. Also answers "k-th matrix of size m×n" lookups for the display and compute stages.

## Interface
- NUM_SLOTS, 8: number of 25-word slots; slot s base = s*25.
- PER_DIM_MAX, 2: maximum stored matrices sharing one (m,n).
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- alloc_en  in  1  requests are honoured only while high (store/generate task active).
- req_valid  in  1  allocation request; level, may stay high 1 cycle after grant.
- req_m, req_n  in  32  dimensions; legal range 1..5.
- base_addr  out  8  granted slot base; valid when addr_ready=1.
- addr_ready  out  1  one-cycle grant pulse.
- alloc_err  out  1  one-cycle pulse, illegal dimension.
- lk_req  in  1  lookup pulse.
- lk_m, lk_n  in  3  lookup dimensions.
- lk_idx  in  2  0 = oldest of that dimension.
- lk_done  out  1  one-cycle completion pulse.
- lk_hit  out  1  entry exists.
- lk_base  out  8  its base address.
- lk_count  out  3  matrices stored with (lk_m,lk_n).
- occupancy  out  4  valid slots.

## Operation
- Per-slot registers: valid, m[2:0], n[2:0], age[3:0]. Age saturates at 15; 0 = newest.
- States: IDLE, A_SCAN, A_COMMIT, GRANT, GUARD, L_SCAN, L_DONE.
- IDLE: if alloc_en && req_valid, check dims.
  - Either outside 1..5: pulse alloc_err, go to GUARD.
  - Otherwise latch dims, go to A_SCAN.
  - Else if lk_req, latch lookup args, go to L_SCAN.
  - Allocation wins a simultaneous request; the lookup stays latched pending and is served on the next IDLE.
- A_SCAN: visits slot 0..NUM_SLOTS-1, one per cycle. Accumulates:
  - first free slot;
  - same-dim count;
  - oldest same-dim slot (largest age, lowest index wins ties);
  - oldest overall slot.
- A_COMMIT victim selection:
  - If same-dim count ≥ PER_DIM_MAX: the oldest same-dim slot.
  - Else the first free slot.
  - Else the oldest overall slot.
  - Write the victim (valid=1, dims, age=0). Increment every other valid slot's age, saturating.
- GRANT: addr_ready=1, base_addr = victim*25. Go to GUARD.
- GUARD: one cycle, req_valid ignored. Absorbs the registered request still high after the grant. Go to IDLE.
- L_SCAN: visits all slots. Counts matches and records the match whose rank among same-dim entries (oldest first) equals lk_idx. L_DONE pulses lk_done with lk_hit/lk_base/lk_count.
- alloc_en low in any state: abort to IDLE, no slot modified, no pulse. Pending lookup is kept.
- Reset mid-scan: all state cleared, next request starts fresh.

## Timing
- Reset values:
  - all slots invalid, ages 0;
  - base_addr=0, addr_ready=0, alloc_err=0;
  - lk_done=0, lk_hit=0, lk_base=0, lk_count=0;
  - occupancy=0.
- Allocation latency: req_valid sampled in IDLE at cycle T. A_SCAN covers T+1..T+NUM_SLOTS, A_COMMIT is T+NUM_SLOTS+1, addr_ready is at T+NUM_SLOTS+2 (10 cycles with default).
- Lookup latency: lk_done at T+NUM_SLOTS+1.
- base_addr and lk_* hold their value after the pulse until the next grant or lookup.
- occupancy updates the cycle after A_COMMIT.
- Arithmetic: victim*25 computed in 8 bits, max 175. m*n is not needed; slots are fixed size.

## Configuration
- MAT_ALLOC_PER_DIM_LIMIT_EN defined: per-dimension limit enforced as above.
- Undefined: PER_DIM_MAX ignored. Victim is the first free slot, else the oldest overall. Same-dim tracking logic is removed. The lookup count is still produced.

## Structure
- Shared package matrix_pkg:
  - SLOT_WORDS=25;
  - DIM_MIN=1, DIM_MAX=5;
  - slot record typedef (valid, m, n, age);
  - state enum.
- One natural sub-module: slot_scan_unit. It is the sequential comparator shared by A_SCAN and L_SCAN and owns the slot index counter and the running best-candidate registers.

## Test plan
- Reset, request 2×3 with alloc_en=1 → addr_ready after 10 cycles, base_addr=0, occupancy=1.
- Three 2×3 requests (limit on) → bases 0, 25, 0. The third replaces the oldest 2×3 entry; occupancy=2.
- Fill 8 slots with distinct dims, then request a 9th → grant to slot 0 (oldest), base_addr=0.
- req_valid held high for one cycle past addr_ready → exactly one grant; no second allocation.
- req_m=6 → alloc_err pulse, no slot change. alloc_en dropped during A_SCAN → no addr_ready, slots unchanged.
- Store 3×3 twice (bases 0, 25); lookup lk_idx=1 → lk_hit=1, lk_base=25, lk_count=2. lk_idx=2 → lk_hit=0.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared types and constants for the matrix store slot allocator.
// Slot records, FSM states, dimension limits and slot base arithmetic.
package matrix_pkg;

  localparam int SLOT_WORDS = 25;
  localparam int DIM_MIN    = 1;
  localparam int DIM_MAX    = 5;

  typedef struct packed {
    logic       valid;
    logic [2:0] m;
    logic [2:0] n;
    logic [3:0] age;
  } slot_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    A_SCAN   = 3'd1,
    A_COMMIT = 3'd2,
    GRANT    = 3'd3,
    GUARD    = 3'd4,
    L_SCAN   = 3'd5,
    L_DONE   = 3'd6
  } state_t;

  function automatic logic dim_ok(input logic [31:0] d);
    return (d >= 32'(DIM_MIN)) && (d <= 32'(DIM_MAX));
  endfunction

  function automatic logic [7:0] slot_base(input logic [7:0] s);
    return s * 8'(SLOT_WORDS);
  endfunction

endpackage

// File: rtl/matrix_slot_allocator_if.sv
// Allocation request / lookup handshake between the front ends and the allocator.
interface matrix_slot_allocator_if;
  logic        req_valid;
  logic [31:0] req_m;
  logic [31:0] req_n;
  logic [7:0]  base_addr;
  logic        addr_ready;
  logic        alloc_err;
  logic        lk_req;
  logic [2:0]  lk_m;
  logic [2:0]  lk_n;
  logic [1:0]  lk_idx;
  logic        lk_done;
  logic        lk_hit;
  logic [7:0]  lk_base;
  logic [2:0]  lk_count;

  modport master (
    output req_valid, req_m, req_n, lk_req, lk_m, lk_n, lk_idx,
    input  base_addr, addr_ready, alloc_err, lk_done, lk_hit, lk_base, lk_count
  );

  modport slave (
    input  req_valid, req_m, req_n, lk_req, lk_m, lk_n, lk_idx,
    output base_addr, addr_ready, alloc_err, lk_done, lk_hit, lk_base, lk_count
  );
endinterface

// File: rtl/slot_scan_unit.sv
// Sequential slot comparator shared by allocation and lookup scans; one slot per step.
// Oldest same-dimension tracking exists only with MAT_ALLOC_PER_DIM_LIMIT_EN.
module slot_scan_unit
  import matrix_pkg::*;
#(
  parameter int NUM_SLOTS = 8,
  parameter int IDX_W     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  step,
  input  slot_t [NUM_SLOTS-1:0] slots,
  input  logic [2:0]            cmp_m,
  input  logic [2:0]            cmp_n,
  input  logic [1:0]            want_rank,
  output logic                  last,
  output logic                  free_found,
  output logic [IDX_W-1:0]      free_idx,
  output logic [IDX_W-1:0]      oldest_idx,
`ifdef MAT_ALLOC_PER_DIM_LIMIT_EN
  output logic [3:0]            same_cnt,
  output logic [IDX_W-1:0]      same_idx,
`endif
  output logic [3:0]            cnt_nxt,
  output logic                  hit_nxt,
  output logic [IDX_W-1:0]      hit_idx_nxt
);

  logic [IDX_W-1:0] idx_r, free_idx_r, all_idx_r, hit_idx_r;
  logic [3:0]       all_age_r, cnt_r, rank_s;
  logic             free_found_r, hit_r;
  slot_t            cur_s;
  logic             match_s, free_take_s, all_take_s, hit_take_s;

  assign cur_s       = slots[idx_r];
  assign match_s     = cur_s.valid && (cur_s.m == cmp_m) && (cur_s.n == cmp_n);
  assign free_take_s = !cur_s.valid && !free_found_r;
  assign all_take_s  = (idx_r == {IDX_W{1'b0}}) || (cur_s.age > all_age_r);
  assign hit_take_s  = match_s && (rank_s == {2'b00, want_rank});
  assign last        = (idx_r == IDX_W'(NUM_SLOTS - 1));

  // Rank of the current slot among its dimension group: entries older, ties to lower index.
  always_comb begin
    rank_s = 4'd0;
    for (int j = 0; j < NUM_SLOTS; j++) begin
      if (slots[j].valid && (slots[j].m == cmp_m) && (slots[j].n == cmp_n) &&
          ((slots[j].age > cur_s.age) ||
           ((slots[j].age == cur_s.age) && (IDX_W'(j) < idx_r)))) begin
        rank_s = rank_s + 4'd1;
      end else begin
        rank_s = rank_s;
      end
    end
  end

  // Slot index and running best-candidate registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r        <= {IDX_W{1'b0}};
      free_found_r <= 1'b0;
      free_idx_r   <= {IDX_W{1'b0}};
      all_idx_r    <= {IDX_W{1'b0}};
      all_age_r    <= 4'd0;
      cnt_r        <= 4'd0;
      hit_r        <= 1'b0;
      hit_idx_r    <= {IDX_W{1'b0}};
    end else if (clr) begin
      idx_r        <= {IDX_W{1'b0}};
      free_found_r <= 1'b0;
      free_idx_r   <= {IDX_W{1'b0}};
      all_idx_r    <= {IDX_W{1'b0}};
      all_age_r    <= 4'd0;
      cnt_r        <= 4'd0;
      hit_r        <= 1'b0;
      hit_idx_r    <= {IDX_W{1'b0}};
    end else if (step) begin
      idx_r        <= last ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
      free_found_r <= free_found_r | free_take_s;
      free_idx_r   <= free_take_s ? idx_r : free_idx_r;
      all_idx_r    <= all_take_s ? idx_r : all_idx_r;
      all_age_r    <= all_take_s ? cur_s.age : all_age_r;
      cnt_r        <= cnt_nxt;
      hit_r        <= hit_nxt;
      hit_idx_r    <= hit_idx_nxt;
    end
  end

`ifdef MAT_ALLOC_PER_DIM_LIMIT_EN
  logic [IDX_W-1:0] same_idx_r;
  logic [3:0]       same_age_r;
  logic             same_take_s;

  assign same_take_s = match_s && ((cnt_r == 4'd0) || (cur_s.age > same_age_r));

  // Oldest slot sharing the requested dimensions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      same_idx_r <= {IDX_W{1'b0}};
      same_age_r <= 4'd0;
    end else if (clr) begin
      same_idx_r <= {IDX_W{1'b0}};
      same_age_r <= 4'd0;
    end else if (step && same_take_s) begin
      same_idx_r <= idx_r;
      same_age_r <= cur_s.age;
    end
  end

  assign same_cnt = cnt_r;
  assign same_idx = same_idx_r;
`endif

  assign free_found  = free_found_r;
  assign free_idx    = free_idx_r;
  assign oldest_idx  = all_idx_r;
  assign cnt_nxt     = cnt_r + {3'b000, match_s};
  assign hit_nxt     = hit_r | hit_take_s;
  assign hit_idx_nxt = hit_take_s ? idx_r : hit_idx_r;

endmodule

// File: rtl/matrix_slot_allocator.sv
// Fixed 25-word slot allocator and directory for the matrix store.
// MAT_ALLOC_PER_DIM_LIMIT_EN enables the per-dimension capacity with oldest-first replacement.
module matrix_slot_allocator
  import matrix_pkg::*;
#(
  parameter int NUM_SLOTS = 8
`ifdef MAT_ALLOC_PER_DIM_LIMIT_EN
  , parameter int PER_DIM_MAX = 2
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc_en,
  matrix_slot_allocator_if.slave bus,
  output logic [3:0]             occupancy
);

  localparam int IDX_W = $clog2(NUM_SLOTS);

  state_t                state_r, state_s;
  slot_t [NUM_SLOTS-1:0] slots_r;
  logic [2:0]            am_r, an_r, lm_r, ln_r, lk_count_r, cmp_m_s, cmp_n_s;
  logic [1:0]            lidx_r;
  logic                  lk_pend_r, addr_ready_r, alloc_err_r, lk_done_r, lk_hit_r;
  logic [7:0]            base_addr_r, lk_base_r;
  logic [3:0]            occupancy_r, cnt_nxt_s;
  logic                  scan_clr_s, scan_step_s, alloc_go_s, lk_go_s, err_s, commit_s, lk_fin_s;
  logic                  scan_last_s, free_found_s, hit_nxt_s, lk_latch_s;
  logic [IDX_W-1:0]      free_idx_s, oldest_idx_s, hit_idx_s, victim_s;
`ifdef MAT_ALLOC_PER_DIM_LIMIT_EN
  logic [3:0]            same_cnt_s;
  logic [IDX_W-1:0]      same_idx_s;
`endif

  assign cmp_m_s    = (state_r == L_SCAN) ? lm_r : am_r;
  assign cmp_n_s    = (state_r == L_SCAN) ? ln_r : an_r;
  assign lk_latch_s = bus.lk_req && (state_r != L_SCAN);

  slot_scan_unit #(.NUM_SLOTS(NUM_SLOTS), .IDX_W(IDX_W)) u_scan (
    .clk(clk), .rst(rst), .clr(scan_clr_s), .step(scan_step_s),
    .slots(slots_r), .cmp_m(cmp_m_s), .cmp_n(cmp_n_s), .want_rank(lidx_r),
    .last(scan_last_s), .free_found(free_found_s), .free_idx(free_idx_s),
    .oldest_idx(oldest_idx_s),
`ifdef MAT_ALLOC_PER_DIM_LIMIT_EN
    .same_cnt(same_cnt_s), .same_idx(same_idx_s),
`endif
    .cnt_nxt(cnt_nxt_s), .hit_nxt(hit_nxt_s), .hit_idx_nxt(hit_idx_s)
  );

  // Victim choice from the completed allocation scan.
  always_comb begin
    victim_s = oldest_idx_s;
`ifdef MAT_ALLOC_PER_DIM_LIMIT_EN
    if (same_cnt_s >= 4'(PER_DIM_MAX)) begin
      victim_s = same_idx_s;
    end else if (free_found_s) begin
      victim_s = free_idx_s;
    end else begin
      victim_s = oldest_idx_s;
    end
`else
    if (free_found_s) begin
      victim_s = free_idx_s;
    end else begin
      victim_s = oldest_idx_s;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Next state and per-cycle strobes; lookups are not cut short by alloc_en.
  always_comb begin
    state_s     = state_r;
    scan_clr_s  = 1'b0;
    scan_step_s = 1'b0;
    alloc_go_s  = 1'b0;
    lk_go_s     = 1'b0;
    err_s       = 1'b0;
    commit_s    = 1'b0;
    lk_fin_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (alloc_en && bus.req_valid) begin
          if (dim_ok(bus.req_m) && dim_ok(bus.req_n)) begin
            alloc_go_s = 1'b1;
            scan_clr_s = 1'b1;
            state_s    = A_SCAN;
          end else begin
            err_s   = 1'b1;
            state_s = GUARD;
          end
        end else if (bus.lk_req || lk_pend_r) begin
          lk_go_s    = 1'b1;
          scan_clr_s = 1'b1;
          state_s    = L_SCAN;
        end else begin
          state_s = IDLE;
        end
      end
      A_SCAN: begin
        if (!alloc_en) begin
          state_s = IDLE;
        end else begin
          scan_step_s = 1'b1;
          state_s     = scan_last_s ? A_COMMIT : A_SCAN;
        end
      end
      A_COMMIT: begin
        if (!alloc_en) begin
          state_s = IDLE;
        end else begin
          commit_s = 1'b1;
          state_s  = GRANT;
        end
      end
      GRANT:  state_s = alloc_en ? GUARD : IDLE;
      GUARD:  state_s = IDLE;
      L_SCAN: begin
        scan_step_s = 1'b1;
        if (scan_last_s) begin
          lk_fin_s = 1'b1;
          state_s  = L_DONE;
        end else begin
          state_s = L_SCAN;
        end
      end
      L_DONE:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Latched request arguments and the pending-lookup flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      am_r      <= 3'd0;
      an_r      <= 3'd0;
      lm_r      <= 3'd0;
      ln_r      <= 3'd0;
      lidx_r    <= 2'd0;
      lk_pend_r <= 1'b0;
    end else begin
      if (alloc_go_s) begin
        am_r <= bus.req_m[2:0];
        an_r <= bus.req_n[2:0];
      end
      if (lk_latch_s) begin
        lm_r   <= bus.lk_m;
        ln_r   <= bus.lk_n;
        lidx_r <= bus.lk_idx;
      end
      if (lk_go_s)         lk_pend_r <= 1'b0;
      else if (lk_latch_s) lk_pend_r <= 1'b1;
    end
  end

  // Slot table: write the victim as newest and age every other valid slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slots_r <= '{default: '0};
    end else if (commit_s) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (IDX_W'(i) == victim_s) begin
          slots_r[i] <= '{valid: 1'b1, m: am_r, n: an_r, age: 4'd0};
        end else if (slots_r[i].valid && (slots_r[i].age != 4'd15)) begin
          slots_r[i].age <= slots_r[i].age + 4'd1;
        end
      end
    end
  end

  // Registered handshake, lookup result and occupancy outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_ready_r <= 1'b0;
      alloc_err_r  <= 1'b0;
      lk_done_r    <= 1'b0;
      base_addr_r  <= 8'd0;
      lk_hit_r     <= 1'b0;
      lk_base_r    <= 8'd0;
      lk_count_r   <= 3'd0;
      occupancy_r  <= 4'd0;
    end else begin
      addr_ready_r <= commit_s;
      alloc_err_r  <= err_s;
      lk_done_r    <= lk_fin_s;
      if (commit_s) begin
        base_addr_r <= slot_base(8'(victim_s));
        occupancy_r <= occupancy_r + {3'b000, !slots_r[victim_s].valid};
      end
      if (lk_fin_s) begin
        lk_hit_r   <= hit_nxt_s;
        lk_base_r  <= hit_nxt_s ? slot_base(8'(hit_idx_s)) : 8'd0;
        lk_count_r <= (cnt_nxt_s > 4'd7) ? 3'd7 : cnt_nxt_s[2:0];
      end
    end
  end

  assign bus.base_addr  = base_addr_r;
  assign bus.addr_ready = addr_ready_r;
  assign bus.alloc_err  = alloc_err_r;
  assign bus.lk_done    = lk_done_r;
  assign bus.lk_hit     = lk_hit_r;
  assign bus.lk_base    = lk_base_r;
  assign bus.lk_count   = lk_count_r;
  assign occupancy      = occupancy_r;

endmodule

// File: tb/tb_matrix_slot_allocator.sv
// Directed self-checking bench for matrix_slot_allocator (either MAT_ALLOC_PER_DIM_LIMIT_EN setting).
module tb_matrix_slot_allocator;

`ifdef MAT_ALLOC_PER_DIM_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       alloc_en;
  logic [3:0] occupancy;
  int         n_chk  = 0;
  int         n_pass = 0;

  matrix_slot_allocator_if bus ();

  matrix_slot_allocator dut (
    .clk(clk), .rst(rst), .alloc_en(alloc_en), .bus(bus.slave), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.lk_req    = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Request held until the grant is seen, then one more cycle, as the front end does.
  task automatic do_alloc(input string tag, input logic [31:0] m, input logic [31:0] n,
                          input logic [7:0] exp_base, input logic [3:0] exp_occ, input bit with_lk);
    int lat = 99;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_m     = m;
    bus.req_n     = n;
    bus.lk_req    = with_lk;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      bus.lk_req = 1'b0;
      if (bus.addr_ready) begin
        lat = k;
        break;
      end
    end
    check_eq({tag, " latency"}, lat, 10);
    check_eq({tag, " base"}, bus.base_addr, exp_base);
    check_eq({tag, " occupancy"}, occupancy, exp_occ);
    @(negedge clk);
    check_eq({tag, " pulse"}, bus.addr_ready, 1'b0);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_lk(input string tag, input int exp_lat, input logic exp_hit,
                         input logic [7:0] exp_base, input logic [2:0] exp_cnt);
    int lat = 99;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      bus.lk_req = 1'b0;
      if (bus.lk_done) begin
        lat = k;
        break;
      end
    end
    check_eq({tag, " latency"}, lat, exp_lat);
    check_eq({tag, " hit"}, bus.lk_hit, exp_hit);
    if (exp_hit) check_eq({tag, " base"}, bus.lk_base, exp_base);
    check_eq({tag, " count"}, bus.lk_count, exp_cnt);
    @(negedge clk);
    check_eq({tag, " done pulse"}, bus.lk_done, 1'b0);
    check_eq({tag, " hit hold"}, bus.lk_hit, exp_hit);
  endtask

  task automatic do_lookup(input string tag, input logic [2:0] m, input logic [2:0] n,
                           input logic [1:0] idx, input logic exp_hit,
                           input logic [7:0] exp_base, input logic [2:0] exp_cnt);
    @(negedge clk);
    bus.lk_req = 1'b1;
    bus.lk_m   = m;
    bus.lk_n   = n;
    bus.lk_idx = idx;
    wait_lk(tag, 9, exp_hit, exp_base, exp_cnt);
  endtask

  task automatic do_err(input string tag, input logic [31:0] m, input logic [31:0] n,
                        input logic [3:0] exp_occ);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_m     = m;
    bus.req_n     = n;
    @(negedge clk);
    check_eq({tag, " err pulse"}, bus.alloc_err, 1'b1);
    check_eq({tag, " no grant"}, bus.addr_ready, 1'b0);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check_eq({tag, " err clear"}, bus.alloc_err, 1'b0);
    check_eq({tag, " occupancy"}, occupancy, exp_occ);
  endtask

  task automatic quiet_window(input string tag, input int cycles);
    int grants = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (bus.addr_ready) grants++;
    end
    check_eq({tag, " no grant"}, grants, 0);
  endtask

  logic [31:0] fill_m [8] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd2, 32'd2, 32'd2};
  logic [31:0] fill_n [8] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd1, 32'd2, 32'd3};

  initial begin
    rst           = 1'b1;
    alloc_en      = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_m     = 32'd0;
    bus.req_n     = 32'd0;
    bus.lk_req    = 1'b0;
    bus.lk_m      = 3'd0;
    bus.lk_n      = 3'd0;
    bus.lk_idx    = 2'd0;
    do_reset();
    @(negedge clk);
    check_eq("rst base_addr", bus.base_addr, 8'd0);
    check_eq("rst addr_ready", bus.addr_ready, 1'b0);
    check_eq("rst alloc_err", bus.alloc_err, 1'b0);
    check_eq("rst lk_done", bus.lk_done, 1'b0);
    check_eq("rst lk_hit", bus.lk_hit, 1'b0);
    check_eq("rst lk_base", bus.lk_base, 8'd0);
    check_eq("rst lk_count", bus.lk_count, 3'd0);
    check_eq("rst occupancy", occupancy, 4'd0);

    do_alloc("a1 2x3", 32'd2, 32'd3, 8'd0, 4'd1, 1'b0);
    quiet_window("after a1", 12);
    check_eq("after a1 occupancy", occupancy, 4'd1);
    check_eq("after a1 base hold", bus.base_addr, 8'd0);
    do_alloc("a2 2x3", 32'd2, 32'd3, 8'd25, 4'd2, 1'b0);
    do_alloc("a3 2x3", 32'd2, 32'd3, LIMIT ? 8'd0 : 8'd50, LIMIT ? 4'd2 : 4'd3, 1'b0);
    do_lookup("lk 2x3 idx0", 3'd2, 3'd3, 2'd0, 1'b1, LIMIT ? 8'd25 : 8'd0, LIMIT ? 3'd2 : 3'd3);

    do_err("m=6", 32'd6, 32'd2, LIMIT ? 4'd2 : 4'd3);
    do_err("n=0", 32'd1, 32'd0, LIMIT ? 4'd2 : 4'd3);
    do_err("m wide", 32'h0000_0102, 32'd2, LIMIT ? 4'd2 : 4'd3);

    // Drop alloc_en a few cycles into the slot scan.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_m     = 32'd4;
    bus.req_n     = 32'd4;
    repeat (3) @(negedge clk);
    alloc_en      = 1'b0;
    bus.req_valid = 1'b0;
    quiet_window("abort", 15);
    alloc_en = 1'b1;
    check_eq("abort occupancy", occupancy, LIMIT ? 4'd2 : 4'd3);
    do_lookup("lk 4x4 after abort", 3'd4, 3'd4, 2'd0, 1'b0, 8'd0, 3'd0);

    // Reset in the middle of a scan.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_m     = 32'd5;
    bus.req_n     = 32'd5;
    repeat (4) @(negedge clk);
    do_reset();
    quiet_window("mid reset", 12);
    check_eq("mid reset occupancy", occupancy, 4'd0);
    check_eq("mid reset base", bus.base_addr, 8'd0);

    for (int i = 0; i < 8; i++) begin
      do_alloc($sformatf("fill%0d", i), fill_m[i], fill_n[i], 8'(i * 25), 4'(i + 1), 1'b0);
    end
    do_alloc("ninth 3x1", 32'd3, 32'd1, 8'd0, 4'd8, 1'b0);
    do_lookup("lk 1x1 evicted", 3'd1, 3'd1, 2'd0, 1'b0, 8'd0, 3'd0);
    do_lookup("lk 2x3 last", 3'd2, 3'd3, 2'd0, 1'b1, 8'd175, 3'd1);

    do_reset();
    do_alloc("b1 3x3", 32'd3, 32'd3, 8'd0, 4'd1, 1'b0);
    do_alloc("b2 3x3", 32'd3, 32'd3, 8'd25, 4'd2, 1'b0);
    do_lookup("lk 3x3 idx1", 3'd3, 3'd3, 2'd1, 1'b1, 8'd25, 3'd2);
    do_lookup("lk 3x3 idx2", 3'd3, 3'd3, 2'd2, 1'b0, 8'd0, 3'd2);
    do_lookup("lk 3x3 idx0", 3'd3, 3'd3, 2'd0, 1'b1, 8'd0, 3'd2);

    // Lookup arriving with an allocation waits and is served afterwards.
    bus.lk_m   = 3'd3;
    bus.lk_n   = 3'd3;
    bus.lk_idx = 2'd0;
    do_alloc("b3 3x3+lk", 32'd3, 32'd3, LIMIT ? 8'd0 : 8'd50, LIMIT ? 4'd2 : 4'd3, 1'b1);
    wait_lk("pending lk", 10, 1'b1, LIMIT ? 8'd25 : 8'd0, LIMIT ? 3'd2 : 3'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
